// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch handshake, writeback port and the execute bundle.
// The decode stage takes the slave side; fetch/writeback/execute logic takes the master side.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            flush;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] data1;
    logic [XLEN-1:0] data2;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
    logic [XLEN-1:0] pc_out;

    modport slave (
        input  if_valid, if_instr, if_pc, flush, wb_en, wb_rd, wb_data, ex_ready,
        output if_ready, ex_valid, data1, data2, opcode, func3, func7, rd, rd_we,
               illegal, pc_out
    );

    modport master (
        output if_valid, if_instr, if_pc, flush, wb_en, wb_rd, wb_data, ex_ready,
        input  if_ready, ex_valid, data1, data2, opcode, func3, func7, rd, rd_we,
               illegal, pc_out
    );
endinterface

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: integer register file, immediate formation and a
// single registered bundle slot feeding the combinational ALU.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [6:0] {
        OP_R     = 7'b0110011,
        OP_IMM   = 7'b0010011,
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111
    } opcode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } bundle_t;

    state_e          state_q;
    bundle_t         out_q;
    bundle_t         out_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic            accept;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd_fld;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic signed [11:0] imm_i;
    logic signed [31:0] imm_u;

    assign rs1    = bus.if_instr[19:15];
    assign rs2    = bus.if_instr[24:20];
    assign rd_fld = bus.if_instr[11:7];
    assign imm_i  = bus.if_instr[31:20];
    assign imm_u  = {bus.if_instr[31:12], 12'b0};

    // Readiness looks only at the slot and the consumer; flush does not gate it.
    assign bus.if_ready = (state_q == ST_EMPTY) || bus.ex_ready;
    assign accept       = bus.if_valid && bus.if_ready;

    // Operand read with write-through bypass from the writeback port; x0 reads zero.
    always_comb begin
        // NOTE: each combinational output is given a default first so no path can infer a latch.
        rs1_val = '0;
        if (rs1 != 5'd0 && int'(rs1) < NREG) rs1_val = regs_q[rs1[AW-1:0]];
        if (bus.wb_en && bus.wb_rd == rs1 && rs1 != 5'd0) rs1_val = bus.wb_data;
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0 && int'(rs2) < NREG) rs2_val = regs_q[rs2[AW-1:0]];
        if (bus.wb_en && bus.wb_rd == rs2 && rs2 != 5'd0) rs2_val = bus.wb_data;
    end

    always_comb begin
        out_d        = '0;
        out_d.opcode = bus.if_instr[6:0];
        out_d.func3  = bus.if_instr[14:12];
        out_d.rd     = rd_fld;
        out_d.pc     = bus.if_pc;
        case (bus.if_instr[6:0])
            OP_R: begin
                out_d.data1 = rs1_val;
                out_d.data2 = rs2_val;
                out_d.func7 = bus.if_instr[31:25];
                out_d.rd_we = 1'b1;
            end
            OP_IMM: begin
                out_d.data1 = rs1_val;
                out_d.data2 = XLEN'(imm_i);
                // Only the shift forms carry a meaningful func7 (the SRAI/SRLI selector).
                if (bus.if_instr[14:12] == 3'b001 || bus.if_instr[14:12] == 3'b101)
                    out_d.func7 = bus.if_instr[31:25];
                out_d.rd_we = 1'b1;
            end
            OP_LUI: begin
                out_d.data2 = XLEN'(imm_u);
                out_d.func3 = 3'b000;
                out_d.rd_we = 1'b1;
            end
            OP_AUIPC: begin
                out_d.data1 = bus.if_pc;
                out_d.data2 = XLEN'(imm_u);
                out_d.func3 = 3'b000;
                out_d.rd_we = 1'b1;
            end
            default: begin
                out_d.illegal = 1'b1;
            end
        endcase
        if (rd_fld == 5'd0) out_d.rd_we = 1'b0;
    end

    // Output slot: flush wins over accept and hold; a stalled bundle stays frozen.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
        end else if (bus.flush) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q <= ST_FULL;
                        out_q   <= out_d;
                    end
                end
                ST_FULL: begin
                    if (accept) begin
                        out_q <= out_d;
                    end else if (bus.ex_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    // Writeback port is independent of stall and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file must clear on reset, so it is built from resettable flops, not an inferred RAM.
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (bus.wb_en && bus.wb_rd != 5'd0 && int'(bus.wb_rd) < NREG) begin
            regs_q[bus.wb_rd[AW-1:0]] <= bus.wb_data;
        end
    end

    assign bus.ex_valid = (state_q == ST_FULL);
    assign bus.data1    = out_q.data1;
    assign bus.data2    = out_q.data2;
    assign bus.opcode   = out_q.opcode;
    assign bus.func3    = out_q.func3;
    assign bus.func7    = out_q.func7;
    assign bus.rd       = out_q.rd;
    assign bus.rd_we    = out_q.rd_we;
    assign bus.illegal  = out_q.illegal;
    assign bus.pc_out   = out_q.pc;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// stall/flush/reset sequences, then randomized traffic against a reference model.
module tb_decode_stage;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN)) bus ();
    decode_stage #(.XLEN(XLEN), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d1, d2, pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        we, ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr, pc;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] e_d1, e_d2;
        logic [2:0]  e_f3;
        logic [6:0]  e_f7;
        logic [4:0]  e_rd;
        logic        e_we, e_ill;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] m_regs [32];
    logic        m_valid;
    exp_t        m_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_bundle(input string p, input exp_t e);
        check($sformatf("%s ex_valid", p), bus.ex_valid, 1'b1);
        check($sformatf("%s data1", p), bus.data1, e.d1);
        check($sformatf("%s data2", p), bus.data2, e.d2);
        check($sformatf("%s opcode", p), bus.opcode, e.op);
        check($sformatf("%s func3", p), bus.func3, e.f3);
        check($sformatf("%s func7", p), bus.func7, e.f7);
        check($sformatf("%s rd", p), bus.rd, e.rd);
        check($sformatf("%s rd_we", p), bus.rd_we, e.we);
        check($sformatf("%s illegal", p), bus.illegal, e.ill);
        check($sformatf("%s pc_out", p), bus.pc_out, e.pc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.flush    = 1'b0;
        bus.wb_en    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.ex_ready = 1'b1;
    endtask

    // Architectural read as seen in the accept cycle: x0 is zero, a same-cycle write wins.
    function automatic logic [31:0] m_read(input int r);
        if (r == 0) return 32'd0;
        if (bus.wb_en && int'(bus.wb_rd) == r) return bus.wb_data;
        return m_regs[r];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   imm;
        e.op  = ins[6:0];
        e.f3  = ins[14:12];
        e.rd  = ins[11:7];
        e.pc  = pc;
        e.d1  = 32'd0;
        e.d2  = 32'd0;
        e.f7  = 7'd0;
        e.we  = 1'b0;
        e.ill = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                e.d1 = m_read(int'(ins[19:15]));
                e.d2 = m_read(int'(ins[24:20]));
                e.f7 = ins[31:25];
                e.we = 1'b1;
            end
            7'b0010011: begin
                e.d1 = m_read(int'(ins[19:15]));
                imm  = int'(ins[31:20]);
                if (imm >= 2048) imm = imm - 4096;
                e.d2 = 32'(imm);
                if (e.f3 == 3'd1 || e.f3 == 3'd5) e.f7 = ins[31:25];
                e.we = 1'b1;
            end
            7'b0110111: begin
                e.d2 = ins & 32'hFFFF_F000;
                e.f3 = 3'd0;
                e.we = 1'b1;
            end
            7'b0010111: begin
                e.d1 = pc;
                e.d2 = ins & 32'hFFFF_F000;
                e.f3 = 3'd0;
                e.we = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic rand_cycle();
        logic [31:0] ins;
        logic        exp_ready;
        logic        acc;
        exp_t        nb;
        ins = $urandom;
        case ($urandom_range(0, 5))
            0: ins[6:0] = 7'b0110011;
            1: ins[6:0] = 7'b0010011;
            2: ins[6:0] = 7'b0110111;
            3: ins[6:0] = 7'b0010111;
            4: ins[6:0] = 7'b0000011;
            default: ins[6:0] = 7'($urandom_range(0, 127));
        endcase
        ins[19:15]   = 5'($urandom_range(0, 7));
        ins[24:20]   = 5'($urandom_range(0, 7));
        ins[11:7]    = 5'($urandom_range(0, 7));
        bus.if_instr = ins;
        bus.if_pc    = $urandom;
        bus.if_valid = ($urandom_range(0, 9) < 7);
        bus.ex_ready = ($urandom_range(0, 9) < 7);
        bus.flush    = ($urandom_range(0, 11) == 0);
        bus.wb_en    = 1'($urandom_range(0, 1));
        bus.wb_rd    = 5'($urandom_range(0, 7));
        bus.wb_data  = $urandom;
        #1;
        exp_ready = !m_valid || bus.ex_ready;
        check("rand if_ready", bus.if_ready, exp_ready);
        acc = bus.if_valid && exp_ready;
        nb  = model_decode(ins, bus.if_pc);
        if (bus.flush) m_valid = 1'b0;
        else if (acc) begin
            m_valid = 1'b1;
            m_b     = nb;
        end else if (bus.ex_ready) m_valid = 1'b0;
        if (bus.wb_en && bus.wb_rd != 5'd0) m_regs[bus.wb_rd] = bus.wb_data;
        step();
        check("rand ex_valid", bus.ex_valid, m_valid);
        if (m_valid) check_bundle("rand", m_b);
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        step();
    endtask

    initial begin
        exp_t e;
        vecs[0]  = '{32'h002081B3, 32'h0000_0000, 1'b0, 5'd0, 32'h0,  32'd5,    32'd6,         3'd0, 7'h00, 5'd3, 1'b1, 1'b0};
        vecs[1]  = '{32'hFFF08293, 32'h0000_0004, 1'b0, 5'd0, 32'h0,  32'd5,    32'hFFFF_FFFF, 3'd0, 7'h00, 5'd5, 1'b1, 1'b0};
        vecs[2]  = '{32'h4030D213, 32'h0000_0008, 1'b0, 5'd0, 32'h0,  32'd5,    32'h0000_0403, 3'd5, 7'h20, 5'd4, 1'b1, 1'b0};
        vecs[3]  = '{32'h123453B7, 32'h0000_000C, 1'b0, 5'd0, 32'h0,  32'd0,    32'h1234_5000, 3'd0, 7'h00, 5'd7, 1'b1, 1'b0};
        vecs[4]  = '{32'h00001097, 32'h0000_0100, 1'b0, 5'd0, 32'h0,  32'h100,  32'h0000_1000, 3'd0, 7'h00, 5'd1, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000A103, 32'h0000_0104, 1'b0, 5'd0, 32'h0,  32'd0,    32'd0,         3'd2, 7'h00, 5'd2, 1'b0, 1'b1};
        vecs[6]  = '{32'h00208033, 32'h0000_0108, 1'b0, 5'd0, 32'h0,  32'd5,    32'd6,         3'd0, 7'h00, 5'd0, 1'b0, 1'b0};
        vecs[7]  = '{32'h40110333, 32'h0000_010C, 1'b0, 5'd0, 32'h0,  32'd6,    32'd5,         3'd0, 7'h20, 5'd6, 1'b1, 1'b0};
        vecs[8]  = '{32'h7FF06413, 32'h0000_0110, 1'b0, 5'd0, 32'h0,  32'd0,    32'h0000_07FF, 3'd6, 7'h00, 5'd8, 1'b1, 1'b0};
        vecs[9]  = '{32'h002081B3, 32'h0000_0114, 1'b1, 5'd1, 32'hAA, 32'hAA,   32'd6,         3'd0, 7'h00, 5'd3, 1'b1, 1'b0};
        vecs[10] = '{32'h002081B3, 32'h0000_0118, 1'b0, 5'd0, 32'h0,  32'hAA,   32'd6,         3'd0, 7'h00, 5'd3, 1'b1, 1'b0};
        vecs[11] = '{32'h002004B3, 32'h0000_011C, 1'b1, 5'd0, 32'h55, 32'd0,    32'd6,         3'd0, 7'h00, 5'd9, 1'b1, 1'b0};
        vecs[12] = '{32'h002004B3, 32'h0000_0120, 1'b0, 5'd0, 32'h0,  32'd0,    32'd6,         3'd0, 7'h00, 5'd9, 1'b1, 1'b0};

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset ex_valid", bus.ex_valid, 1'b0);
        check("reset if_ready", bus.if_ready, 1'b1);
        check("reset data1", bus.data1, 32'd0);
        check("reset data2", bus.data2, 32'd0);
        check("reset rd_we", bus.rd_we, 1'b0);
        check("reset pc_out", bus.pc_out, 32'd0);
        rst = 1'b0;

        bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd5;
        step();
        bus.wb_rd = 5'd2; bus.wb_data = 32'd6;
        step();
        bus.wb_en = 1'b0;

        foreach (vecs[i]) begin
            bus.if_valid = 1'b1;
            bus.ex_ready = 1'b1;
            bus.if_instr = vecs[i].instr;
            bus.if_pc    = vecs[i].pc;
            bus.wb_en    = vecs[i].wb_en;
            bus.wb_rd    = vecs[i].wb_rd;
            bus.wb_data  = vecs[i].wb_data;
            step();
            bus.wb_en = 1'b0;
            e.d1 = vecs[i].e_d1;  e.d2 = vecs[i].e_d2;  e.pc = vecs[i].pc;
            e.op = vecs[i].instr[6:0];  e.f3 = vecs[i].e_f3;  e.f7 = vecs[i].e_f7;
            e.rd = vecs[i].e_rd;  e.we = vecs[i].e_we;  e.ill = vecs[i].e_ill;
            check_bundle($sformatf("vec%0d", i), e);
        end

        // Stall: bundle frozen for three cycles, then replaced with no bubble.
        send(32'h002081B3, 32'h200);
        bus.ex_ready = 1'b0;
        bus.if_instr = 32'h123453B7;
        bus.if_pc    = 32'h204;
        #1;
        check("stall if_ready", bus.if_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall ex_valid", bus.ex_valid, 1'b1);
            check("stall data1", bus.data1, 32'hAA);
            check("stall data2", bus.data2, 32'd6);
            check("stall pc_out", bus.pc_out, 32'h200);
        end
        bus.ex_ready = 1'b1;
        #1;
        check("release if_ready", bus.if_ready, 1'b1);
        step();
        check("b2b ex_valid", bus.ex_valid, 1'b1);
        check("b2b data2", bus.data2, 32'h1234_5000);
        check("b2b pc_out", bus.pc_out, 32'h204);

        // Flush in an accept cycle discards the incoming instruction.
        bus.if_instr = 32'h002081B3;
        bus.flush    = 1'b1;
        step();
        check("flush accept ex_valid", bus.ex_valid, 1'b0);
        bus.flush = 1'b0;
        send(32'h002081B3, 32'h300);
        bus.if_valid = 1'b0;
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b1;
        #1;
        check("flush stalled if_ready", bus.if_ready, 1'b0);
        step();
        check("flush stalled ex_valid", bus.ex_valid, 1'b0);
        bus.flush = 1'b0;

        // Reset mid-stall drops the bundle at once and clears the register file.
        bus.ex_ready = 1'b1;
        send(32'h002081B3, 32'h400);
        bus.if_valid = 1'b0;
        bus.ex_ready = 1'b0;
        step();
        check("pre-rst ex_valid", bus.ex_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst async ex_valid", bus.ex_valid, 1'b0);
        check("rst async data1", bus.data1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        bus.ex_ready = 1'b1;
        send(32'h002081B3, 32'h500);
        check("post-rst data1", bus.data1, 32'd0);
        check("post-rst data2", bus.data2, 32'd0);
        check("post-rst ex_valid", bus.ex_valid, 1'b1);
        bus.if_valid = 1'b0;
        step();
        check("drain ex_valid", bus.ex_valid, 1'b0);

        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        m_valid = 1'b0;
        m_b     = e;
        for (int n = 0; n < 400; n++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
